// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: shared ALU opcodes, multiplier types, condition/shift codes and decode helpers.
package instruction_decode_pkg;
  localparam logic [3:0] OP_AND = 4'd0, OP_EOR = 4'd1, OP_SUB = 4'd2, OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4, OP_ADC = 4'd5, OP_SBC = 4'd6, OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8, OP_TEQ = 4'd9, OP_CMP = 4'd10, OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;
  localparam logic [2:0] MT_MUL = 3'b000, MT_MLA = 3'b001, MT_UMULL = 3'b100;
  localparam logic [2:0] MT_UMLAL = 3'b101, MT_SMULL = 3'b110, MT_SMLAL = 3'b111;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;
  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;
  typedef enum logic {EMPTY, STALL} state_t;
  // Odd condition codes are the inverse of their even partner; AL passes, NV fails.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = n == v;
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction
  // R15 reads are never stalled on the scoreboard.
  function automatic logic busy_hit(input logic [15:0] busy, input logic [3:0] r);
    return r != 4'hf && busy[r];
  endfunction
endpackage

// File: rtl/instruction_decode_barrel_shifter.sv
// instruction_decode_barrel_shifter: immediate-amount shifter (LSL/LSR/ASR/ROR/RRX).
// Ports: value/amount/shift_type/carry in, result out; amount 0 encodes LSR/ASR #32 and RRX.
module instruction_decode_barrel_shifter
  import instruction_decode_pkg::*;
(
  input  logic [31:0] value,
  input  logic [4:0]  amount,
  input  logic [1:0]  shift_type,
  input  logic        carry,
  output logic [31:0] result
);
  logic [31:0] rot, asr;
  assign rot = 32'({value, value} >> amount);
  assign asr = $signed(value) >>> amount;
  always_comb
    result = shift_type == SH_LSL ? value << amount
           : shift_type == SH_LSR ? (amount == 5'd0 ? 32'd0 : value >> amount)
           : shift_type == SH_ASR ? (amount == 5'd0 ? {32{value[31]}} : asr)
           : (amount == 5'd0 ? {carry, value[31:1]} : rot);
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: decode stage issuing one registered micro-op per ARM instruction.
// Ports: fetch handshake (instr_valid_i/instr_i/pc_i/instr_ready_o, flush_i), cpsr_i,
// register-file read addresses/data, writeback clears (wb_*), micro-op outputs (exec_o,
// dest/dest_hi, write enables, cycle flags, operands a-d, opcode, type, undef_o).
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  input  logic [31:0] cpsr_i,
  output logic [3:0]  rn_addr_o,
  output logic [3:0]  rm_addr_o,
  output logic [3:0]  rs_addr_o,
  output logic [3:0]  rd_addr_o,
  output logic [3:0]  rdhi_addr_o,
  input  logic [31:0] rn_data_i,
  input  logic [31:0] rm_data_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] rdhi_data_i,
  input  logic        wb_valid_i,
  input  logic [3:0]  wb_reg_i,
  input  logic        wb_cpsr_i,
  output logic        exec_o,
  output logic [3:0]  dest_o,
  output logic [3:0]  dest_hi_o,
  output logic        write_dest_do_o,
  output logic        write_dest_m_o,
  output logic        write_cpsr_o,
  output logic [31:0] do_cycle_o,
  output logic [31:0] m_ma_cycle_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [3:0]  opcode_o,
  output logic [2:0]  type_o,
  output logic        undef_o
);
  state_t state, state_n;
  logic [31:0] hold, hold_pc, ins, pc, pc8;
  logic [31:0] rn_v, rm_v, rs_v, rd_v, rdhi_v, sh_val, sh_out;
  logic [15:0] busy, set_bits, clr_bits;
  logic fbusy, valid_in, is_mul, is_dp, lng, acc, unsup, pass, rrx, hazard, issue;
  logic use_rn, use_rm, use_rs, use_rd, use_rdhi, wdo, wm, wc;
  logic [3:0] dp_op, cond, dest, dest_hi;
  logic [4:0] sh_amt;
  logic [1:0] sh_type;
  logic unused_cpsr;
  assign unused_cpsr = ^cpsr_i[27:0];
  assign ins = state == STALL ? hold : instr_i;
  assign pc = state == STALL ? hold_pc : pc_i;
  assign pc8 = pc + 32'd8;
  assign valid_in = state == STALL || instr_valid_i;
  assign instr_ready_o = state == EMPTY;
  assign rn_addr_o = ins[19:16];
  assign rm_addr_o = ins[3:0];
  assign rs_addr_o = ins[11:8];
  assign rd_addr_o = ins[15:12];
  assign rdhi_addr_o = ins[19:16];
  assign rn_v = rn_addr_o == 4'hf ? pc8 : rn_data_i;
  assign rm_v = rm_addr_o == 4'hf ? pc8 : rm_data_i;
  assign rs_v = rs_addr_o == 4'hf ? pc8 : rs_data_i;
  assign rd_v = rd_addr_o == 4'hf ? pc8 : rd_data_i;
  assign rdhi_v = rdhi_addr_o == 4'hf ? pc8 : rdhi_data_i;
  assign cond = ins[31:28];
  assign dp_op = ins[24:21];
  assign is_mul = ins[27:24] == 4'b0000 && ins[7:4] == 4'b1001;
  assign is_dp = ins[27:26] == 2'b00 && !is_mul;
  assign lng = ins[23];
  assign acc = ins[21];
  assign unsup = cond == COND_NV || !(is_mul || is_dp) || (is_dp && !ins[25] && ins[4])
               || (is_mul && !lng && ins[22]);
  assign pass = cond_pass(cond, cpsr_i[31:28]) && !unsup;
  assign use_rn = is_dp && dp_op != OP_MOV && dp_op != OP_MVN;
  assign use_rm = (is_dp && !ins[25]) || is_mul;
  assign use_rs = is_mul;
  assign use_rd = is_mul && acc;
  assign use_rdhi = is_mul && lng && acc;
  assign rrx = is_dp && !ins[25] && ins[11:7] == 5'd0 && ins[6:5] == SH_ROR;
  assign hazard = !unsup && ((use_rn && busy_hit(busy, rn_addr_o)) || (use_rm && busy_hit(busy, rm_addr_o))
               || (use_rs && busy_hit(busy, rs_addr_o)) || (use_rd && busy_hit(busy, rd_addr_o))
               || (use_rdhi && busy_hit(busy, rdhi_addr_o)) || (fbusy && (cond != COND_AL || rrx)));
  assign issue = valid_in && !hazard && !flush_i;
  // Immediate form: imm8 rotated by 2*rot; rot 0 must not fall into the RRX encoding.
  assign sh_val = ins[25] ? {24'd0, ins[7:0]} : rm_v;
  assign sh_amt = ins[25] ? {ins[11:8], 1'b0} : ins[11:7];
  assign sh_type = ins[25] ? (ins[11:8] == 4'd0 ? SH_LSL : SH_ROR) : ins[6:5];
  instruction_decode_barrel_shifter u_shifter (
    .value(sh_val), .amount(sh_amt), .shift_type(sh_type), .carry(cpsr_i[29]), .result(sh_out)
  );
  assign wdo = pass && is_dp && dp_op[3:2] != 2'b10;
  assign wm = pass && is_mul;
  assign wc = pass && ins[20];
  assign dest = is_mul && !lng ? ins[19:16] : ins[15:12];
  assign dest_hi = is_mul && lng ? ins[19:16] : 4'd0;
  assign set_bits = (wdo || wm ? 16'd1 << dest : 16'd0) | (wm && lng ? 16'd1 << dest_hi : 16'd0);
  assign clr_bits = wb_valid_i ? 16'd1 << wb_reg_i : 16'd0;
  always_comb
    state_n = flush_i ? EMPTY : (valid_in && hazard ? STALL : EMPTY);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      hold <= '0;
      hold_pc <= '0;
      busy <= '0;
      fbusy <= 1'b0;
      exec_o <= 1'b0;
      undef_o <= 1'b0;
      dest_o <= '0;
      dest_hi_o <= '0;
      write_dest_do_o <= 1'b0;
      write_dest_m_o <= 1'b0;
      write_cpsr_o <= 1'b0;
      do_cycle_o <= '0;
      m_ma_cycle_o <= '0;
      a_o <= '0;
      b_o <= '0;
      c_o <= '0;
      d_o <= '0;
      opcode_o <= '0;
      type_o <= '0;
    end else begin
      state <= state_n;
      if (state == EMPTY && instr_valid_i) begin
        hold <= instr_i;
        hold_pc <= pc_i;
      end
      // A set and a clear of the same bit in one cycle resolve to set.
      busy <= (busy & ~clr_bits) | (issue ? set_bits : 16'd0);
      fbusy <= (fbusy && !wb_cpsr_i) || (issue && wc);
      exec_o <= issue;
      undef_o <= issue && unsup;
      if (issue) begin
        dest_o <= dest;
        dest_hi_o <= dest_hi;
        write_dest_do_o <= wdo;
        write_dest_m_o <= wm;
        write_cpsr_o <= wc;
        do_cycle_o <= {31'd0, pass && is_dp};
        m_ma_cycle_o <= {31'd0, wm};
        a_o <= is_mul ? rm_v : rn_v;
        b_o <= is_mul ? rs_v : sh_out;
        c_o <= is_mul ? rd_v : 32'd0;
        d_o <= is_mul && lng ? rdhi_v : 32'd0;
        opcode_o <= is_dp ? dp_op : 4'd0;
        type_o <= is_mul ? ins[23:21] : 3'd0;
      end
    end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the core pipeline, directly upstream of `instruction_execute`. It accepts 32-bit ARM instruction words from fetch over a valid/ready handshake and evaluates the condition field against the CPSR. It reads source operands from the register file and issues one registered micro-op per instruction: control flags, operands `a`–`d`, ALU opcode and multiplier type. A busy scoreboard stalls any instruction whose sources or flags are still in flight.

## Interface
Parameters: none.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `instr_valid_i` input 1: fetch has an instruction.
- `instr_i` input 32: instruction word.
- `pc_i` input 32: address of `instr_i`.
- `instr_ready_o` output 1: decode can accept this cycle.
- `flush_i` input 1: discard the held instruction and any instruction being accepted.
- `cpsr_i` input 32: current CPSR; bits 31:28 are NZCV.
- `rn_addr_o`, `rm_addr_o`, `rs_addr_o`, `rd_addr_o`, `rdhi_addr_o` output 4 each: register-file read addresses (combinational).
- `rn_data_i`, `rm_data_i`, `rs_data_i`, `rd_data_i`, `rdhi_data_i` input 32 each: read data, same cycle.
- `wb_valid_i` input 1: writeback has committed a register this cycle.
- `wb_reg_i` input 4: register committed.
- `wb_cpsr_i` input 1: writeback has committed CPSR flags this cycle.
- `exec_o` output 1: micro-op valid; one-cycle pulse per issue.
- `dest_o` output 4: Rd, or RdLo for long multiplies.
- `dest_hi_o` output 4: RdHi; routed around execute to writeback.
- `write_dest_do_o`, `write_dest_m_o`, `write_cpsr_o` output 1 each: write enables.
- `do_cycle_o`, `m_ma_cycle_o` output 32 each: bit 0 is the flag, bits 31:1 are always 0.
- `a_o`, `b_o`, `c_o`, `d_o` output 32 each: operands.
- `opcode_o` output 4: ALU opcode.
- `type_o` output 3: multiplier type.
- `undef_o` output 1: one-cycle pulse on an unsupported encoding.

## Operation
- State machine, two states:
  - EMPTY: `instr_ready_o` = 1. An accepted instruction issues at the next edge if there is no hazard. If there is a hazard, it is latched into the hold register and the state moves to STALL.
  - STALL: `instr_ready_o` = 0. The hold register is re-evaluated every cycle. On issue, the state returns to EMPTY.
- Condition: the 4-bit condition field is evaluated against NZCV. AL (0xE) always passes. NV (0xF) is unsupported.
- A failed condition issues a NOP:
  - `exec_o` = 1.
  - Both cycle flags, all write enables and all busy-bit sets are 0.
- Data processing (`instr[27:26]` = 00 and not a multiply):
  - `opcode_o` = `instr[24:21]`; `a_o` = Rn; `dest_o` = Rd.
  - `write_cpsr_o` = S.
  - `write_dest_do_o` = 0 for opcodes 8–11, otherwise 1.
  - `do_cycle_o` = 1.
  - Immediate operand: `b_o` = imm8 rotated right by 2×rot.
  - Register operand with immediate shift: LSL, LSR, ASR, ROR.
    - LSR #0 and ASR #0 mean a shift of 32.
    - ROR #0 means RRX using C.
  - Register-specified shift (`instr[4]` = 1): unsupported.
- Multiply (`instr[27:24]` = 0000 and `instr[7:4]` = 1001):
  - `type_o` = `instr[23:21]`: {long, signed, accumulate}. Bit 22 must be 0 for short forms.
  - `a_o` = Rm, `b_o` = Rs.
  - Short forms: `c_o` = Rn (accumulator), `dest_o` = `instr[19:16]`, `d_o` = 0.
  - Long forms: `c_o` = RdLo, `d_o` = RdHi, `dest_o` = RdLo, `dest_hi_o` = RdHi.
  - `m_ma_cycle_o` = 1; `write_dest_m_o` = 1; `write_cpsr_o` = S.
- An unsupported encoding issues a NOP and pulses `undef_o` in the same cycle as `exec_o`.
- R15 as a source reads `pc_i` + 8 for the held instruction, not the register file. R15 is never treated as busy for reads.
- Scoreboard, 16 busy bits plus one flags bit:
  - On issue: set the bit of every written destination, and set the flags bit if `write_cpsr_o` = 1.
  - `wb_valid_i` clears bit `wb_reg_i`; `wb_cpsr_i` clears the flags bit.
  - A set and a clear of the same bit in the same cycle: the set wins.
- Hazard conditions:
  - Any used source register is busy.
  - The condition is not AL and the flags bit is set.
  - For data processing with a register operand and RRX, the flags bit is set.
- Flush: discards the held or incoming instruction, `exec_o` = 0 at the next edge, and the state returns to EMPTY. The scoreboard is retained.

## Timing
- Reset values:
  - `exec_o`, `undef_o` and all write enables: 0.
  - All data outputs, `dest_o` and `dest_hi_o`: 0.
  - `instr_ready_o` = 1; state EMPTY; scoreboard all clear.
- Reset mid-STALL drops the held instruction.
- Latency: an instruction accepted at edge N with no hazard has outputs valid after N and `exec_o` high for one cycle. Outputs hold their values until the next issue, but `exec_o` drops.
- A busy bit cleared at edge M allows issue at edge M+1. No bypass from writeback.
- `flush_i` together with an accept: flush wins and the instruction is not issued.

## Structure
- Shared package:
  - Opcode constants for the 16 ALU operations.
  - Multiplier `type` encodings: 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL.
  - Condition codes and shift-type codes.
- Sub-module: `barrel_shifter`, combinational, for immediate rotate and immediate shifts, including RRX. Inputs: value, amount, type, carry.

## Test plan
- Reset: assert `rst` while in STALL → `exec_o` = 0, `instr_ready_o` = 1 after release; a following instruction reading the previously busy register issues without stall.
- `0xE2821CFF` (ADD r1,r2,#0xFF ror 24) with r2 = 5 → one `exec_o` pulse with:
  - `a_o` = 5, `b_o` = `0x0000FF00`, `opcode_o` = 4;
  - `dest_o` = 1, `do_cycle_o` = 1, `write_dest_do_o` = 1.
- EQ instruction with Z = 0 → NOP: `exec_o` = 1, `do_cycle_o` = 0, no busy bit set.
- ADD r1 followed by `0xE2413001` (SUB r3,r1,#1):
  - the SUB stalls and `instr_ready_o` = 0;
  - `wb_valid_i` with `wb_reg_i` = 1 at edge M → the SUB issues at edge M+1 with the new r1 value.
- `0xE0A54392` (UMLAL r4,r5,r2,r3) → `type_o` = 101, `a_o` = r2, `b_o` = r3, `c_o` = r4, `d_o` = r5, `dest_o` = 4, `dest_hi_o` = 5, `write_dest_m_o` = 1; busy bits 4 and 5 set.
- `0xE1A00062` (MOV r0,r2,RRX) with r2 = 2 and C = 1 → `b_o` = `0x80000001`. Repeat with `flush_i` in the accept cycle → no `exec_o` pulse.
